// File: rtl/tt_um_multich_pulse_gen_if.sv
// rtl/tt_um_multich_pulse_gen_if.sv - pin bundle of the multichannel pulse generator
interface tt_um_multich_pulse_gen_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ena, ui_in, uio_in,
        input  uo_out, uio_out, uio_oe
    );

    modport slave (
        input  ena, ui_in, uio_in,
        output uo_out, uio_out, uio_oe
    );
endinterface

// File: rtl/tt_um_multich_pulse_gen.sv
// rtl/tt_um_multich_pulse_gen.sv - four-channel lockstep pulse-train generator
module tt_um_multich_pulse_gen #(
    parameter int PW  = 4,
    parameter int GAP = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    tt_um_multich_pulse_gen_if.slave    bus
);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    localparam logic [7:0] PW_T  = 8'(PW - 1);
    localparam logic [7:0] GAP_T = 8'(GAP - 1);

    state_t     state;
    logic [7:0] timer;
    logic [3:0] cfg [4];
    logic [3:0] rem [4];
    logic [3:0] next_cfg [4];
    logic [3:0] pulse;
    logic       aborted;
    logic       done;
    logic       busy;
    logic       load_q;
    logic       start_q;

    logic       load_ev;
    logic       start_ev;
    logic       abort_lvl;
    logic [1:0] sel;
    logic       cfg_any;
    logic       rem_any;

    assign load_ev   = bus.ui_in[7] & ~load_q;
    assign start_ev  = bus.uio_in[0] & ~start_q;
    assign abort_lvl = bus.uio_in[1];
    assign sel       = bus.ui_in[6:5];

    // Configuration as seen by a start on this edge: a same-cycle load wins.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            next_cfg[i] = cfg[i];
        end
        if (load_ev && state == IDLE) begin
            next_cfg[sel] = bus.ui_in[3:0];
        end
        cfg_any = 1'b0;
        rem_any = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cfg_any = cfg_any | (next_cfg[i] != 4'd0);
            rem_any = rem_any | (rem[i] != 4'd0);
        end
    end

    // Edge detectors, channel configuration and the IDLE/HIGH/LOW phase sequencer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            timer   <= 8'd0;
            pulse   <= 4'd0;
            aborted <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
            load_q  <= 1'b0;
            start_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                cfg[i] <= 4'd0;
                rem[i] <= 4'd0;
            end
        end else begin
            load_q  <= bus.ui_in[7];
            start_q <= bus.uio_in[0];
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    for (int i = 0; i < 4; i++) begin
                        cfg[i] <= next_cfg[i];
                    end
                    if (start_ev) begin
                        aborted <= 1'b0;
                        for (int i = 0; i < 4; i++) begin
                            rem[i] <= next_cfg[i];
                        end
                        if (!cfg_any) begin
                            done <= 1'b1;
                        end else begin
                            state <= HIGH;
                            timer <= PW_T;
                            busy  <= 1'b1;
                            for (int i = 0; i < 4; i++) begin
                                pulse[i] <= (next_cfg[i] != 4'd0);
                            end
                        end
                    end
                end
                HIGH: begin
                    if (abort_lvl) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        pulse   <= 4'd0;
                        aborted <= 1'b1;
                        for (int i = 0; i < 4; i++) begin
                            rem[i] <= 4'd0;
                        end
                    end else if (timer == 8'd0) begin
                        state <= LOW;
                        timer <= GAP_T;
                        pulse <= 4'd0;
                        for (int i = 0; i < 4; i++) begin
                            if (rem[i] != 4'd0) begin
                                rem[i] <= rem[i] - 4'd1;
                            end
                        end
                    end else begin
                        timer <= timer - 8'd1;
                    end
                end
                LOW: begin
                    if (abort_lvl) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        pulse   <= 4'd0;
                        aborted <= 1'b1;
                        for (int i = 0; i < 4; i++) begin
                            rem[i] <= 4'd0;
                        end
                    end else if (timer == 8'd0) begin
                        if (!rem_any) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= HIGH;
                            timer <= PW_T;
                            for (int i = 0; i < 4; i++) begin
                                pulse[i] <= (rem[i] != 4'd0);
                            end
                        end
                    end else begin
                        timer <= timer - 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    pulse <= 4'd0;
                end
            endcase
        end
    end

    assign bus.uo_out  = {busy, done, aborted, 1'b0, pulse};
    assign bus.uio_out = {rem[sel], 4'd0};
    assign bus.uio_oe  = 8'hF0;

    wire unused_ok = &{1'b0, bus.ena, bus.ui_in[4], bus.uio_in[7:2]};

endmodule

// File: tb/tb_tt_um_multich_pulse_gen.sv
// tb/tb_tt_um_multich_pulse_gen.sv - directed self-checking bench for the pulse generator
module tb_tt_um_multich_pulse_gen;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    tt_um_multich_pulse_gen_if bus  ();
    tt_um_multich_pulse_gen_if bus1 ();

    tt_um_multich_pulse_gen #(.PW(4), .GAP(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    tt_um_multich_pulse_gen #(.PW(1), .GAP(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected pulse bits for the PW=GAP=4 build, k cycles after the start edge.
    function automatic logic [3:0] exp_pulse(input logic [15:0] c, input int k);
        logic [3:0] p;
        for (int i = 0; i < 4; i++) begin
            p[i] = ((k % 8) < 4) && ((k / 8) < int'(c[4*i +: 4]));
        end
        return p;
    endfunction

    // Expected remaining count for the PW=GAP=4 build.
    function automatic logic [3:0] exp_rem(input logic [3:0] c, input int k);
        int d;
        d = (k + 4) / 8;
        if (d >= int'(c)) return 4'd0;
        return 4'(int'(c) - d);
    endfunction

    task automatic do_load(input logic [1:0] ch, input logic [3:0] v);
        bus.ui_in = {1'b1, ch, 1'b0, v};
        tick();
        bus.ui_in[7] = 1'b0;
        tick();
    endtask

    task automatic do_start();
        bus.uio_in[0] = 1'b1;
        tick();
        bus.uio_in[0] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.ui_in   = 8'($urandom);
            bus.uio_in  = 8'($urandom);
            bus1.ui_in  = 8'($urandom);
            bus1.uio_in = 8'($urandom);
            tick();
        end
        n_checks++;
        if (bus.uo_out !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_uo_out got %h expected 00", bus.uo_out);
        end
        n_checks++;
        if (bus.uio_out !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_uio_out got %h expected 00", bus.uio_out);
        end
        n_checks++;
        if (bus.uio_oe !== 8'hF0) begin
            n_fail++;
            $display("FAIL reset_uio_oe got %h expected F0", bus.uio_oe);
        end
        n_checks++;
        if (bus1.uo_out !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_uo_out_pw1 got %h expected 00", bus1.uo_out);
        end
        bus.ui_in   = 8'h00;
        bus.uio_in  = 8'h00;
        bus1.ui_in  = 8'h00;
        bus1.uio_in = 8'h00;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_main_run();
        logic [7:0] exp_uo;
        logic [7:0] exp_uio;
        do_load(2'd0, 4'd3);
        do_load(2'd1, 4'd1);
        do_load(2'd2, 4'd0);
        do_load(2'd3, 4'd15);
        bus.ui_in = {1'b0, 2'd3, 5'd0};
        do_start();
        for (int k = 0; k < 120; k++) begin
            exp_uo  = {4'b1000, exp_pulse(16'hF013, k)};
            exp_uio = {exp_rem(4'd15, k), 4'd0};
            n_checks++;
            if (bus.uo_out !== exp_uo || bus.uio_out !== exp_uio) begin
                n_fail++;
                $display("FAIL main_run k=%0d uo_out=%h uio_out=%h expected %h %h",
                         k, bus.uo_out, bus.uio_out, exp_uo, exp_uio);
            end
            tick();
        end
        n_checks++;
        if (bus.uo_out !== 8'h40) begin
            n_fail++;
            $display("FAIL main_done got %h expected 40", bus.uo_out);
        end
        tick();
        n_checks++;
        if (bus.uo_out !== 8'h00) begin
            n_fail++;
            $display("FAIL main_after_done got %h expected 00", bus.uo_out);
        end
    endtask

    task automatic test_all_zero();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        bus.ui_in = 8'h00;
        do_start();
        n_checks++;
        if (bus.uo_out !== 8'h40) begin
            n_fail++;
            $display("FAIL zero_done got %h expected 40", bus.uo_out);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if (bus.uo_out !== 8'h00) begin
                n_fail++;
                $display("FAIL zero_idle k=%0d got %h expected 00", k, bus.uo_out);
            end
        end
    endtask

    task automatic test_abort();
        logic [7:0] exp_uo;
        do_load(2'd0, 4'd5);
        bus.ui_in = 8'h00;
        do_start();
        for (int k = 0; k < 10; k++) begin
            exp_uo = {4'b1000, exp_pulse(16'h0005, k)};
            n_checks++;
            if (bus.uo_out !== exp_uo) begin
                n_fail++;
                $display("FAIL abort_run k=%0d got %h expected %h", k, bus.uo_out, exp_uo);
            end
            if (k == 9) bus.uio_in[1] = 1'b1;
            tick();
        end
        n_checks++;
        if (bus.uo_out !== 8'h20 || bus.uio_out !== 8'h00) begin
            n_fail++;
            $display("FAIL abort_hit uo_out=%h uio_out=%h expected 20 00", bus.uo_out, bus.uio_out);
        end
        bus.uio_in[1] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++;
            if (bus.uo_out !== 8'h20) begin
                n_fail++;
                $display("FAIL abort_hold k=%0d got %h expected 20", k, bus.uo_out);
            end
        end
        do_start();
        for (int k = 0; k < 40; k++) begin
            exp_uo = {4'b1000, exp_pulse(16'h0005, k)};
            n_checks++;
            if (bus.uo_out !== exp_uo) begin
                n_fail++;
                $display("FAIL abort_replay k=%0d got %h expected %h", k, bus.uo_out, exp_uo);
            end
            tick();
        end
        n_checks++;
        if (bus.uo_out !== 8'h40) begin
            n_fail++;
            $display("FAIL abort_replay_done got %h expected 40", bus.uo_out);
        end
        tick();
    endtask

    task automatic test_ignored();
        logic [7:0] exp_uo;
        logic [7:0] exp_uio;
        for (int pass = 0; pass < 2; pass++) begin
            bus.ui_in = 8'h00;
            do_start();
            for (int k = 0; k < 40; k++) begin
                exp_uo  = {4'b1000, exp_pulse(16'h0005, k)};
                exp_uio = {exp_rem(4'd5, k), 4'd0};
                n_checks++;
                if (bus.uo_out !== exp_uo || bus.uio_out !== exp_uio) begin
                    n_fail++;
                    $display("FAIL ignored pass=%0d k=%0d uo_out=%h uio_out=%h expected %h %h",
                             pass, k, bus.uo_out, bus.uio_out, exp_uo, exp_uio);
                end
                if (pass == 0) begin
                    if (k == 2) bus.ui_in = {1'b1, 2'd0, 1'b0, 4'd9};
                    if (k == 3) bus.ui_in[7] = 1'b0;
                    if (k == 5) bus.uio_in[0] = 1'b1;
                    if (k == 6) bus.uio_in[0] = 1'b0;
                end
                tick();
            end
            n_checks++;
            if (bus.uo_out !== 8'h40) begin
                n_fail++;
                $display("FAIL ignored_done pass=%0d got %h expected 40", pass, bus.uo_out);
            end
            tick();
        end
    endtask

    task automatic test_pw1();
        logic [7:0] exp_uo  [5];
        logic [7:0] exp_uio [5];
        exp_uo  = '{8'h84, 8'h80, 8'h84, 8'h80, 8'h40};
        exp_uio = '{8'h20, 8'h10, 8'h10, 8'h00, 8'h00};
        bus1.ui_in = {1'b1, 2'd2, 1'b0, 4'd2};
        tick();
        bus1.ui_in[7] = 1'b0;
        tick();
        bus1.uio_in[0] = 1'b1;
        tick();
        bus1.uio_in[0] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (bus1.uo_out !== exp_uo[k] || bus1.uio_out !== exp_uio[k]) begin
                n_fail++;
                $display("FAIL pw1 k=%0d uo_out=%h uio_out=%h expected %h %h",
                         k, bus1.uo_out, bus1.uio_out, exp_uo[k], exp_uio[k]);
            end
            tick();
        end
        n_checks++;
        if (bus1.uo_out !== 8'h00) begin
            n_fail++;
            $display("FAIL pw1_idle got %h expected 00", bus1.uo_out);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.ena     = 1'b1;
        bus.ui_in   = 8'h00;
        bus.uio_in  = 8'h00;
        bus1.ena    = 1'b1;
        bus1.ui_in  = 8'h00;
        bus1.uio_in = 8'h00;
        tick();
        test_reset();
        test_main_run();
        test_all_zero();
        test_abort();
        test_ignored();
        test_pw1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
